// File: rtl/freq_switch_pkg.sv
// Shared state encodings, clock-source codes and a small sizing helper
// for the clock-source switch controller.
package freq_switch_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_ACK    = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   localparam logic SRC_CLK1 = 1'b0;
   localparam logic SRC_CLK2 = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/freq_switch_ctrl_rr_arbiter.sv
// Combinational round-robin picker: returns the first set request bit at or
// after rr_ptr, wrapping modulo N_REQ.
module rr_arbiter #(
   parameter int N_REQ = 4,
   localparam int IDXW = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDXW-1:0]  rr_ptr,
   output logic             valid,
   output logic [IDXW-1:0]  idx
);

   localparam logic [IDXW:0] N_EXT = (IDXW+1)'(N_REQ);

   logic [2*N_REQ-2:0] req_dbl;
   logic [N_REQ-1:0]   req_rot;
   logic [IDXW-1:0]    off;
   logic [IDXW:0]      sum;

   // Rotating through a doubled vector puts rr_ptr's bit at position 0.
   assign req_dbl = {req[N_REQ-2:0], req};
   assign req_rot = req_dbl[rr_ptr +: N_REQ];

   always_comb begin
      valid = 1'b0;
      off   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            valid = 1'b1;
            off   = IDXW'(k);
         end
      end
   end

   assign sum = {1'b0, rr_ptr} + {1'b0, off};
   assign idx = (sum >= N_EXT) ? IDXW'(sum - N_EXT) : sum[IDXW-1:0];

endmodule

// File: rtl/freq_switch_ctrl.sv
// Clock-source request arbiter driving the sel input of a glitch-free
// two-clock switch, with a settle window after each change and a dwell time.
module freq_switch_ctrl
   import freq_switch_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int SETTLE_CYC = 8,
   parameter int HOLD_MIN   = 16,
   localparam int IDXW      = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] req_src,
   output logic             sel,
   output logic [N_REQ-1:0] ack,
   output logic             busy,
   output logic [IDXW-1:0]  cur_owner
);

   localparam int CNT_W = $clog2(max_int(SETTLE_CYC, HOLD_MIN) + 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_MIN > 0 ? HOLD_MIN - 1 : 0);
   localparam logic [IDXW-1:0]  LAST_IDX    = IDXW'(N_REQ - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDXW-1:0]  rr_ptr;
   logic [IDXW-1:0]  win;
   logic             arb_valid;
   logic [IDXW-1:0]  arb_idx;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req    (req),
      .rr_ptr (rr_ptr),
      .valid  (arb_valid),
      .idx    (arb_idx)
   );

   // The target source is committed straight into sel at grant time, so sel
   // itself holds the latched target and later req_src changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         sel       <= SRC_CLK1;
         ack       <= '0;
         busy      <= 1'b0;
         cur_owner <= '0;
         rr_ptr    <= '0;
         cnt       <= '0;
         win       <= '0;
      end else begin
         ack <= '0;
         case (state)
            S_IDLE: begin
               if (arb_valid) begin
                  win  <= arb_idx;
                  busy <= 1'b1;
                  if (req_src[arb_idx] == sel) begin
                     ack[arb_idx] <= 1'b1;
                     state        <= S_ACK;
                  end else begin
                     sel   <= req_src[arb_idx];
                     cnt   <= SETTLE_LOAD;
                     state <= S_SETTLE;
                  end
               end
            end
            S_SETTLE: begin
               if (cnt == '0) begin
                  ack[win] <= 1'b1;
                  state    <= S_ACK;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_ACK: begin
               cur_owner <= win;
               rr_ptr    <= (win == LAST_IDX) ? '0 : win + IDXW'(1);
               if (HOLD_MIN == 0) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt   <= HOLD_LOAD;
                  state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (cnt == '0) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_switch_ctrl.sv
// Scoreboard bench for freq_switch_ctrl: directed requests push expected acks,
// independent monitors pop and compare whenever an ack pulse appears.
module tb_freq_switch_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0, req_src = '0;
   logic       sel, busy;
   logic [3:0] ack;
   logic [1:0] cur_owner;

   logic [3:0] req_h = '0, src_h = '0;
   logic       sel_h, busy_h;
   logic [3:0] ack_h;
   logic [1:0] owner_h;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] ack;
      logic       sel;
      logic [1:0] owner;
      int         cyc;
   } exp_t;

   exp_t q_main[$];
   exp_t q_h0[$];

   freq_switch_ctrl #(.N_REQ(4), .SETTLE_CYC(8), .HOLD_MIN(16)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_src   (req_src),
      .sel       (sel),
      .ack       (ack),
      .busy      (busy),
      .cur_owner (cur_owner)
   );

   freq_switch_ctrl #(.N_REQ(4), .SETTLE_CYC(4), .HOLD_MIN(0)) u_dut_h0 (
      .clk       (clk),
      .rst       (rst),
      .req       (req_h),
      .req_src   (src_h),
      .sel       (sel_h),
      .ack       (ack_h),
      .busy      (busy_h),
      .cur_owner (owner_h)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [3:0] s);
      req     = r;
      req_src = s;
   endtask

   task automatic pushMain(input logic [3:0] a, input logic s, input logic [1:0] o, input int lat);
      exp_t e;
      e.ack = a; e.sel = s; e.owner = o; e.cyc = cyc + lat;
      q_main.push_back(e);
   endtask

   task automatic pushH0(input logic [3:0] a, input logic s, input logic [1:0] o, input int lat);
      exp_t e;
      e.ack = a; e.sel = s; e.owner = o; e.cyc = cyc + lat;
      q_h0.push_back(e);
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic waitIdle();
      int k = 0;
      while (busy !== 1'b0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (busy !== 1'b0) checkOutput("idle timeout", busy, 0);
   endtask

   // Main-instance monitor: every ack pulse must match the head of the queue,
   // and cur_owner must follow one cycle later.
   initial begin
      exp_t e;
      logic       own_pend = 1'b0;
      logic [1:0] own_exp  = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (own_pend) begin
               checkOutput("cur_owner", cur_owner, own_exp);
               own_pend = 1'b0;
            end
            if (ack !== 4'b0000) begin
               if (q_main.size() == 0) begin
                  checkOutput("unexpected ack", ack, 0);
               end else begin
                  e = q_main.pop_front();
                  checkOutput("ack value", ack, e.ack);
                  checkOutput("sel at ack", sel, e.sel);
                  checkOutput("ack cycle", cyc, e.cyc);
                  own_pend = 1'b1;
                  own_exp  = e.owner;
               end
            end
         end
      end
   end

   // Monitor for the zero-dwell instance.
   initial begin
      exp_t e;
      logic       own_pend = 1'b0;
      logic [1:0] own_exp  = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            if (own_pend) begin
               checkOutput("h0 cur_owner", owner_h, own_exp);
               own_pend = 1'b0;
            end
            if (ack_h !== 4'b0000) begin
               if (q_h0.size() == 0) begin
                  checkOutput("h0 unexpected ack", ack_h, 0);
               end else begin
                  e = q_h0.pop_front();
                  checkOutput("h0 ack value", ack_h, e.ack);
                  checkOutput("h0 sel at ack", sel_h, e.sel);
                  checkOutput("h0 ack cycle", cyc, e.cyc);
                  own_pend = 1'b1;
                  own_exp  = e.owner;
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      repeat (3) @(negedge clk);
      checkOutput("reset sel", sel, 0);
      checkOutput("reset ack", ack, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset cur_owner", cur_owner, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("idle busy", busy, 0);

      $display("[TB] same source: req[2] wants clk_1");
      applyStimulus(4'b0100, 4'b0000);
      pushMain(4'b0100, 1'b0, 2'd2, 1);
      c = cyc;
      waitUntil(c + 1);
      req = '0;
      waitIdle();

      $display("[TB] switch: req[0] wants clk_2");
      applyStimulus(4'b0001, 4'b0001);
      pushMain(4'b0001, 1'b1, 2'd0, 9);
      c = cyc;
      waitUntil(c + 1);
      checkOutput("sel after grant", sel, 1);
      checkOutput("busy in settle", busy, 1);
      waitUntil(c + 9);
      req = '0;
      waitIdle();

      $display("[TB] drop mid-switch: req[1] wants clk_1, then changes and drops");
      applyStimulus(4'b0010, 4'b0000);
      pushMain(4'b0010, 1'b0, 2'd1, 9);
      c = cyc;
      waitUntil(c + 2);
      req_src = 4'b0010;
      waitUntil(c + 3);
      req = '0;
      waitUntil(c + 5);
      checkOutput("sel latched mid settle", sel, 0);
      waitUntil(c + 9);
      waitIdle();
      req_src = '0;

      $display("[TB] wrap: req[3] same source moves rr_ptr to 0");
      applyStimulus(4'b1000, 4'b0000);
      pushMain(4'b1000, 1'b0, 2'd3, 1);
      c = cyc;
      waitUntil(c + 1);
      req = '0;
      waitIdle();

      $display("[TB] fairness: all four held, alternating sources");
      applyStimulus(4'b1111, 4'b1010);
      pushMain(4'b0001, 1'b0, 2'd0, 1);
      pushMain(4'b0010, 1'b1, 2'd1, 27);
      pushMain(4'b0100, 1'b0, 2'd2, 53);
      pushMain(4'b1000, 1'b1, 2'd3, 79);
      pushMain(4'b0001, 1'b0, 2'd0, 105);
      c = cyc;
      waitUntil(c + 105);
      req = '0;
      waitIdle();

      $display("[TB] reset mid-settle");
      applyStimulus(4'b0010, 4'b0010);
      c = cyc;
      waitUntil(c + 3);
      checkOutput("sel mid settle", sel, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async reset sel", sel, 0);
      checkOutput("async reset ack", ack, 0);
      checkOutput("async reset busy", busy, 0);
      req = '0;
      req_src = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("busy after reset", busy, 0);

      $display("[TB] rr_ptr restarts at 0 after reset");
      applyStimulus(4'b0011, 4'b0000);
      pushMain(4'b0001, 1'b0, 2'd0, 1);
      pushMain(4'b0010, 1'b0, 2'd1, 19);
      c = cyc;
      waitUntil(c + 1);
      req = 4'b0010;
      waitUntil(c + 19);
      req = '0;
      waitIdle();

      $display("[TB] zero dwell: back-to-back grants");
      req_h = 4'b0111;
      src_h = 4'b0100;
      pushH0(4'b0001, 1'b0, 2'd0, 1);
      pushH0(4'b0010, 1'b0, 2'd1, 3);
      pushH0(4'b0100, 1'b1, 2'd2, 9);
      c = cyc;
      waitUntil(c + 1);
      req_h = 4'b0110;
      waitUntil(c + 3);
      req_h = 4'b0100;
      waitUntil(c + 9);
      req_h = '0;
      waitUntil(c + 12);
      checkOutput("h0 busy after burst", busy_h, 0);

      repeat (5) @(negedge clk);
      checkOutput("main acks outstanding", q_main.size(), 0);
      checkOutput("h0 acks outstanding", q_h0.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
